atan2_cordic: RTL and testbench
===============================

Name: atan2_cordic

Overview:
- Inverse of the sine/cosine approximation blocks: recovers the angle and magnitude of an (x, y) vector.
- Iterative CORDIC in vectoring mode; one micro-rotation per enabled clock.
- Uses the same signed 27-bit fixed-point format as the sincos path, with 8 fractional bits and radians for angles.
- Sits after the sincos/rotation datapath in t_block; used for phase recovery and self-check of sin/cos outputs.

Parameters:
- ITER, 9, micro-rotations performed; legal range 1..12. Table entries for i >= 9 are 0.
- W_INT, 29, internal x/y/z datapath width: 27 plus 2 guard bits for CORDIC gain and pre-rotation.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- en  in  1  global clock enable; when low, all state and outputs hold
- in_valid  in  1  operand valid
- in_ready  out  1  block can accept operands
- x_in  in  27  signed x, 8 fractional bits
- y_in  in  27  signed y, 8 fractional bits
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- angle  out  27  signed atan2(y, x), radians, 8 fractional bits, range [-804, 804]
- mag  out  27  unsigned-in-signed magnitude, 8 fractional bits
- zero_vec  out  1  result came from x = y = 0

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - state = IDLE.
  - in_ready = 1, out_valid = 0, angle = 0, mag = 0, zero_vec = 0.
  - Internal registers cleared.
- State IDLE (in_ready = 1):
  - Accept occurs on an enabled edge with in_valid = 1.
  - Pre-rotation is applied on the accept edge:
    - If x_in < 0: load x = -x_in, y = -y_in, z = (y_in >= 0) ? +PI_Q : -PI_Q, with PI_Q = 804.
    - Otherwise: load x = x_in, y = y_in, z = 0.
  - All values are sign-extended to W_INT. Clear i = 0. Go to ITERATE.
- State ITERATE (in_ready = 0), one step per enabled edge:
  - If y >= 0: x += y>>>i, y -= x>>>i, z += ATAN_LUT[i].
  - Otherwise: x -= y>>>i, y += x>>>i, z -= ATAN_LUT[i].
  - Shifts are arithmetic. All right-hand sides use pre-update values.
  - Increment i. After the step with i = ITER-1, go to DONE.
- State DONE:
  - out_valid = 1. Outputs are registered and stable.
  - Output values:
    - angle = z saturated to [-804, 804].
    - mag = x saturated to [0, 2^26-1].
    - zero_vec = latched (x_in == 0 && y_in == 0) from the accept edge.
  - On an enabled edge with out_ready = 1: out_valid = 0, go to IDLE.
- Zero vector: angle = 0 and mag = 0 are forced regardless of the iteration result.
- Latency: out_valid rises ITER enabled edges after the accept edge (ITER+1 with the optional feature).
  - Throughput: one result per ITER+2 enabled cycles, minimum.
  - No accept in the same cycle as result release: in_ready is 0 throughout DONE.
- en = 0 freezes the state machine, the counter and the handshake; in_valid/out_ready are ignored that cycle.
- Input range: |x_in|, |y_in| <= 2^25-1 is guaranteed overflow-free. Larger inputs give a correct angle; mag saturates.
- Reset asserted mid-ITERATE or DONE: the result is discarded, no out_valid pulse, IDLE after reset release.
- Angle accuracy: within ±3 LSB of round(atan2·256) for ITER = 9.

Optional Feature:
- Macro: ATAN2_MAG_COMP_EN.
- Defined:
  - Adds state COMP, entered after the last iteration.
  - COMP computes mag = round(x · 155 / 256), i.e. the 1/K gain correction with K^-1 ≈ 0.6073. Rounding uses bit 7 (round half up).
  - One extra enabled cycle before DONE.
- Undefined:
  - mag = raw x, carrying CORDIC gain K ≈ 1.6468.
  - No COMP state.

Decomposition:
- Package atan2_cordic_pkg holds:
  - FRAC_BITS = 8, DATA_W = 27, PI_Q = 804.
  - ATAN_LUT[0:11] = {201, 119, 63, 32, 16, 8, 4, 2, 1, 0, 0, 0}.
  - MAG_COMP_COEFF = 155.
  - State enum {IDLE, ITERATE, COMP, DONE}.
- Sub-module cordic_vec_stage: purely combinational single micro-rotation.
  - Inputs: x, y, z, shift i, atan constant.
  - Outputs: next x, y, z.
  - Instantiated once; the top owns the FSM, counter, saturation and handshake.

Test Plan:
1. x = 256, y = 0, out_ready = 1 -> angle 0 ±1; mag 421 ±3 (256 ±2 with ATAN2_MAG_COMP_EN); out_valid exactly ITER cycles after accept.
2. (256, 256) -> angle 201 ±3; (0, 256) -> angle 402 ±3; (0, -256) -> angle -402 ±3; (-256, -256) -> angle -603 ±3.
3. (-256, 0) -> angle 804; (-256, -1) -> angle in [-804, -800]; no value outside ±804.
4. (0, 0) -> angle 0, mag 0, zero_vec 1; the next operand (256, 0) -> zero_vec 0.
5. Hold out_ready = 0 for 5 cycles in DONE while in_valid = 1 -> out_valid, angle and mag stable, in_ready 0, second operand not consumed. Toggling en = 0 for 3 cycles mid-ITERATE extends latency by exactly 3.
6. Pulse reset_n low 4 cycles into ITERATE -> out_valid 0, angle/mag 0 immediately, in_ready 1 after release, no stale result emitted.

Source files
------------

// File: rtl/atan2_cordic_pkg.sv
// atan2_cordic_pkg: shared constants, arctangent table, state encoding and saturation helper
// for the vectoring-mode CORDIC.
package atan2_cordic_pkg;
    localparam int FRAC_BITS = 8;
    localparam int DATA_W = 27;
    localparam int PI_Q = 804;
    localparam int MAG_COMP_COEFF = 155;
    localparam int MAG_MAX = (1 << 26) - 1;
    // round(atan(2^-i) * 256); entries past i = 8 vanish at this precision
    localparam int ATAN_LUT [0:11] = '{201, 119, 63, 32, 16, 8, 4, 2, 1, 0, 0, 0};

    typedef enum logic [1:0] {IDLE, ITERATE, COMP, DONE} state_t;

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [39:0] v,
                                                     input logic signed [39:0] lo,
                                                     input logic signed [39:0] hi);
        return v < lo ? DATA_W'(lo) : v > hi ? DATA_W'(hi) : DATA_W'(v);
    endfunction
endpackage

// File: rtl/atan2_cordic_vec_stage.sv
// cordic_vec_stage: one combinational vectoring micro-rotation, steering y towards zero
// and accumulating the applied angle into z.
module cordic_vec_stage #(
    parameter int W = 29
) (
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] y,
    input  logic signed [W-1:0] z,
    input  logic        [3:0]   shift,
    input  logic signed [W-1:0] atan,
    output logic signed [W-1:0] x_next,
    output logic signed [W-1:0] y_next,
    output logic signed [W-1:0] z_next
);
    logic neg;

    assign neg    = y[W-1];
    assign x_next = neg ? x - (y >>> shift) : x + (y >>> shift);
    assign y_next = neg ? y + (x >>> shift) : y - (x >>> shift);
    assign z_next = neg ? z - atan : z + atan;
endmodule

// File: rtl/atan2_cordic.sv
// atan2_cordic: iterative CORDIC returning atan2(y, x), magnitude and a zero-vector flag.
// Define ATAN2_MAG_COMP_EN to add a COMP state that removes the CORDIC gain from mag.
module atan2_cordic
    import atan2_cordic_pkg::*;
#(
    parameter int ITER  = 9,
    parameter int W_INT = 29
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic signed [DATA_W-1:0] y_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] angle,
    output logic        [DATA_W-1:0] mag,
    output logic                     zero_vec
);
    state_t state;
    logic signed [W_INT-1:0] x, y, z, x_n, y_n, z_n, xe, ye;
    logic [3:0] i;
    logic zv;

    assign xe = W_INT'(x_in);
    assign ye = W_INT'(y_in);

    cordic_vec_stage #(.W(W_INT)) u_stage (
        .x(x), .y(y), .z(z), .shift(i), .atan(W_INT'(ATAN_LUT[i])),
        .x_next(x_n), .y_next(y_n), .z_next(z_n)
    );

`ifdef ATAN2_MAG_COMP_EN
    logic signed [39:0] comp;
    // 155/256 approximates 1/K; half-LSB added before the shift rounds half up
    assign comp = (40'(x) * 40'(MAG_COMP_COEFF) + 40'(1 << (FRAC_BITS - 1))) >>> FRAC_BITS;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            i         <= '0;
            zv        <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            angle     <= '0;
            mag       <= '0;
            zero_vec  <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: if (in_valid) begin
                    // left half-plane: rotate by pi so iterations only cover +-pi/2
                    x        <= x_in < 0 ? -xe : xe;
                    y        <= x_in < 0 ? -ye : ye;
                    z        <= x_in < 0 ? (y_in >= 0 ? W_INT'(PI_Q) : -W_INT'(PI_Q)) : '0;
                    i        <= '0;
                    zv       <= x_in == 0 && y_in == 0;
                    in_ready <= 1'b0;
                    state    <= ITERATE;
                end
                ITERATE: begin
                    x <= x_n;
                    y <= y_n;
                    z <= z_n;
                    i <= i + 4'd1;
                    if (i == 4'(ITER - 1)) begin
`ifdef ATAN2_MAG_COMP_EN
                        state <= COMP;
`else
                        state     <= DONE;
                        out_valid <= 1'b1;
                        zero_vec  <= zv;
                        angle     <= zv ? '0 : sat(40'(z_n), -40'(PI_Q), 40'(PI_Q));
                        mag       <= zv ? '0 : sat(40'(x_n), 40'sd0, 40'(MAG_MAX));
`endif
                    end
                end
`ifdef ATAN2_MAG_COMP_EN
                COMP: begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                    zero_vec  <= zv;
                    angle     <= zv ? '0 : sat(40'(z), -40'(PI_Q), 40'(PI_Q));
                    mag       <= zv ? '0 : sat(comp, 40'sd0, 40'(MAG_MAX));
                end
`endif
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_atan2_cordic.sv
// tb_atan2_cordic: directed-vector bench for atan2_cordic with hand-computed expectations;
// honours ATAN2_MAG_COMP_EN for latency and magnitude.
module tb_atan2_cordic;
`ifdef ATAN2_MAG_COMP_EN
    localparam int LAT = 10, MAG1 = 256, MTOL = 2;
`else
    localparam int LAT = 9, MAG1 = 421, MTOL = 3;
`endif
    logic clk = 0, reset_n = 0, en = 1, in_valid = 0, out_ready = 1;
    logic in_ready, out_valid, zero_vec;
    logic signed [26:0] x_in = 0, y_in = 0, angle;
    logic [26:0] mag;
    int checks = 0, passed = 0;

    atan2_cordic dut (
        .clk(clk), .reset_n(reset_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
        .angle(angle), .mag(mag), .zero_vec(zero_vec)
    );

    always #5 clk = ~clk;

    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int xv, input int yv, output int ang, output int mg,
                          output int zv, output int lat);
        int n = 0;
        while (!in_ready && n < 100) begin tick(); n++; end
        x_in = 27'(xv);
        y_in = 27'(yv);
        in_valid = 1;
        tick();
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 100) begin tick(); lat++; end
        ang = int'(angle);
        mg = int'(mag);
        zv = int'(zero_vec);
        if (out_ready) tick();
    endtask

    task automatic test_reset();
        reset_n = 0;
        tick(); tick();
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        checks++; if (angle !== 27'sd0) $display("FAIL reset_angle: got %0d want 0", angle); else passed++;
        checks++; if (mag !== 27'd0) $display("FAIL reset_mag: got %0d want 0", mag); else passed++;
        checks++; if (zero_vec !== 1'b0) $display("FAIL reset_zero_vec: got %b want 0", zero_vec); else passed++;
        reset_n = 1;
        tick();
    endtask

    task automatic test_basic();
        int a, m, z, l;
        run_op(256, 0, a, m, z, l);
        checks++; if (iabs(a) > 1) $display("FAIL basic_angle: got %0d want 0+-1", a); else passed++;
        checks++; if (iabs(m - MAG1) > MTOL) $display("FAIL basic_mag: got %0d want %0d+-%0d", m, MAG1, MTOL); else passed++;
        checks++; if (l != LAT) $display("FAIL basic_latency: got %0d want %0d", l, LAT); else passed++;
        checks++; if (z != 0) $display("FAIL basic_zero_vec: got %0d want 0", z); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL basic_release: in_ready got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_quadrants();
        int xs[4] = '{256, 0, 0, -256};
        int ys[4] = '{256, 256, -256, -256};
        int ex[4] = '{201, 402, -402, -603};
        int a, m, z, l;
        for (int k = 0; k < 4; k++) begin
            run_op(xs[k], ys[k], a, m, z, l);
            checks++;
            if (iabs(a - ex[k]) > 3) $display("FAIL quad_angle(%0d,%0d): got %0d want %0d+-3", xs[k], ys[k], a, ex[k]);
            else passed++;
        end
    endtask

    task automatic test_boundary();
        int a, m, z, l;
        run_op(-256, 0, a, m, z, l);
        checks++; if (a != 804) $display("FAIL bound_pi: got %0d want 804", a); else passed++;
        run_op(-256, -1, a, m, z, l);
        checks++; if (a < -804 || a > -800) $display("FAIL bound_neg_pi: got %0d want [-804,-800]", a); else passed++;
        run_op(-33554431, 1, a, m, z, l);
        checks++; if (a < 800 || a > 804) $display("FAIL bound_big: got %0d want [800,804]", a); else passed++;
    endtask

    task automatic test_zero();
        int a, m, z, l;
        run_op(0, 0, a, m, z, l);
        checks++; if (a != 0) $display("FAIL zero_angle: got %0d want 0", a); else passed++;
        checks++; if (m != 0) $display("FAIL zero_mag: got %0d want 0", m); else passed++;
        checks++; if (z != 1) $display("FAIL zero_flag: got %0d want 1", z); else passed++;
        run_op(256, 0, a, m, z, l);
        checks++; if (z != 0) $display("FAIL zero_flag_next: got %0d want 0", z); else passed++;
    endtask

    task automatic test_back_to_back();
        int a, m, z, l, stale = 0;
        out_ready = 0;
        run_op(256, 256, a, m, z, l);
        checks++; if (iabs(a - 201) > 3) $display("FAIL hold_angle: got %0d want 201+-3", a); else passed++;
        x_in = 0; y_in = 256; in_valid = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || int'(angle) != a || int'(mag) != m)
                $display("FAIL hold_cycle%0d: got ov=%b ir=%b ang=%0d mag=%0d want ov=1 ir=0 ang=%0d mag=%0d",
                         k, out_valid, in_ready, angle, mag, a, m);
            else passed++;
        end
        out_ready = 1;
        tick();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL hold_release: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
        else passed++;
        for (int k = 0; k < 15; k++) begin tick(); if (out_valid) stale++; end
        checks++; if (stale != 0) $display("FAIL hold_not_consumed: out_valid cycles got %0d want 0", stale); else passed++;
    endtask

    task automatic test_enable();
        int l = 0;
        x_in = 256; y_in = 256; in_valid = 1;
        tick();
        in_valid = 0;
        tick(); l++;
        tick(); l++;
        en = 0;
        for (int k = 0; k < 3; k++) begin tick(); l++; end
        en = 1;
        while (!out_valid && l < 100) begin tick(); l++; end
        checks++; if (l != LAT + 3) $display("FAIL en_latency: got %0d want %0d", l, LAT + 3); else passed++;
        checks++; if (iabs(int'(angle) - 201) > 3) $display("FAIL en_angle: got %0d want 201+-3", angle); else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        int a, m, z, l, stale = 0;
        x_in = 0; y_in = 256; in_valid = 1;
        tick();
        in_valid = 0;
        for (int k = 0; k < 4; k++) tick();
        reset_n = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || angle !== 27'sd0 || mag !== 27'd0 || in_ready !== 1'b1)
            $display("FAIL rst_mid: got ov=%b ang=%0d mag=%0d ir=%b want ov=0 ang=0 mag=0 ir=1",
                     out_valid, angle, mag, in_ready);
        else passed++;
        tick(); tick();
        reset_n = 1;
        for (int k = 0; k < 15; k++) begin tick(); if (out_valid) stale++; end
        checks++; if (stale != 0) $display("FAIL rst_stale: out_valid cycles got %0d want 0", stale); else passed++;
        run_op(256, 0, a, m, z, l);
        checks++; if (iabs(a) > 1 || l != LAT) $display("FAIL rst_recover: got ang=%0d lat=%0d want 0+-1 lat %0d", a, l, LAT); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_quadrants();
        test_boundary();
        test_zero();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
